// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard controller.
// Opcodes follow the LEGv8 encoding; the FSM encoding lives here too.
package hazard_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned OPC_W       = 11;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    // R-type (11-bit opcodes)
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_ADDS = 11'b101_0101_1000;
    localparam logic [10:0] OP_SUBS = 11'b111_0101_1000;

    // D-type
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;

    // I-type (10-bit opcodes)
    localparam logic [9:0] OP_ADDI = 10'b10_0100_0100;
    localparam logic [9:0] OP_SUBI = 10'b11_0100_0100;

    // CB-type (8-bit) and B-type (6-bit)
    localparam logic [7:0] OP_CBZ   = 8'b1011_0100;
    localparam logic [7:0] OP_BCOND = 8'b0101_0100;
    localparam logic [5:0] OP_B     = 6'b00_0101;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    function automatic logic is_rtype(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD)  || (opc == OP_SUB)  || (opc == OP_AND) ||
               (opc == OP_ORR)  || (opc == OP_ADDS) || (opc == OP_SUBS);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational source-register-use decode of the instruction held in ID.
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             uses_rn,
    output logic             uses_rm,
    output logic             uses_rt,
    output logic             is_cbz,
    output logic             is_bcond
);

    logic is_r;
    logic is_imm;
    logic is_ldur;
    logic is_stur;
    logic is_b;

    always_comb begin
        is_r     = is_rtype(opcode);
        is_imm   = (opcode[10:1] == OP_ADDI) || (opcode[10:1] == OP_SUBI);
        is_ldur  = (opcode == OP_LDUR);
        is_stur  = (opcode == OP_STUR);
        is_cbz   = (opcode[10:3] == OP_CBZ);
        is_bcond = (opcode[10:3] == OP_BCOND);
        is_b     = (opcode[10:5] == OP_B);

        // An unconditional branch reads no registers at all.
        uses_rn = !is_b && (is_r || is_imm || is_ldur || is_stur);
        uses_rm = !is_b && is_r;
        uses_rt = !is_b && (is_stur || is_cbz);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and CBZ branch-ALU stalls, branch flush.
// Optional HAZARD_FLAG_EN adds a B.cond stall behind flag-setting EX instructions.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_W-1:0]     IC_in,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [REG_W-1:0]       ex_rd,
`ifdef HAZARD_FLAG_EN
    input  logic                   ex_set_flags,
`endif
    input  logic                   branch_taken,
    output logic                   Hazard_out,
    output logic                   bubble,
    output logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic uses_rn, uses_rm, uses_rt, is_cbz, is_bcond;

    hazard_decode u_decode (
        .opcode   (IC_in[31:21]),
        .uses_rn  (uses_rn),
        .uses_rm  (uses_rm),
        .uses_rt  (uses_rt),
        .is_cbz   (is_cbz),
        .is_bcond (is_bcond)
    );

    logic [REG_W-1:0] rn, rm, rt;
    logic             unused_shamt;

    assign rn           = IC_in[9:5];
    assign rm           = IC_in[20:16];
    assign rt           = IC_in[4:0];
    assign unused_shamt = ^IC_in[15:10];

    logic src_match;
    logic load_use;
    logic branch_alu;
    logic flag_haz;
    logic hazard;

    // XZR never carries a dependency, so it is masked before any match.
    always_comb begin
        src_match  = (ex_rd != XZR) &&
                     ((uses_rn && (rn == ex_rd)) ||
                      (uses_rm && (rm == ex_rd)) ||
                      (uses_rt && (rt == ex_rd)));
        load_use   = ex_mem_read && src_match;
        branch_alu = is_cbz && ex_reg_write && !ex_mem_read &&
                     (ex_rd != XZR) && (rt == ex_rd);
        hazard     = load_use || branch_alu || flag_haz;
    end

`ifdef HAZARD_FLAG_EN
    assign flag_haz = is_bcond && ex_set_flags;
`else
    logic unused_bcond;
    assign unused_bcond = is_bcond;
    assign flag_haz     = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stall;

    // Next state, remaining-cycle counter and stall decision.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        case (state)
            ST_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    // A load feeding CBZ needs the value one cycle later than ALU ops.
                    if (load_use && is_cbz) begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_STALL: begin
                stall   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt_nxt == CNT_W'(0)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = CNT_W'(0);
            end
        endcase
        if (reset) begin
            stall = 1'b0;
        end
    end

    assign Hazard_out = stall;
    assign bubble     = stall;
    assign flush      = branch_taken && !stall && !reset;

    // Updates on the falling edge, in step with the IF/ID register.
    always_ff @(negedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            cnt         <= CNT_W'(0);
            stall_count <= STALL_CNT_W'(0);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall) begin
                stall_count <= stall_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; honours HAZARD_FLAG_EN if defined.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IC_in;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic        Hazard_out;
    logic        bubble;
    logic        flush;
    logic [31:0] stall_count;
`ifdef HAZARD_FLAG_EN
    logic        ex_set_flags;
    localparam logic FLAG_EXP = 1'b1;
`else
    localparam logic FLAG_EXP = 1'b0;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .IC_in        (IC_in),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
`ifdef HAZARD_FLAG_EN
        .ex_set_flags (ex_set_flags),
`endif
        .branch_taken (branch_taken),
        .Hazard_out   (Hazard_out),
        .bubble       (bubble),
        .flush        (flush),
        .stall_count  (stall_count)
    );

    // Hand-encoded LEGv8 instructions
    localparam logic [31:0] ADD_2_1_3   = {11'b10001011000, 5'd3, 6'd0, 5'd1, 5'd2};
    localparam logic [31:0] ADD_2_31_3  = {11'b10001011000, 5'd3, 6'd0, 5'd31, 5'd2};
    localparam logic [31:0] CBZ_4       = {8'b10110100, 19'd2, 5'd4};
    localparam logic [31:0] CBZ_5       = {8'b10110100, 19'd2, 5'd5};
    localparam logic [31:0] STUR_7_6    = {11'b11111000000, 9'd0, 2'b00, 5'd6, 5'd7};
    localparam logic [31:0] B_IMM21     = {6'b000101, 26'h0000021};
    localparam logic [31:0] ADDI_2_3    = {10'b1001000100, 12'd5, 5'd3, 5'd2};
    localparam logic [31:0] ADDI_IMM9   = {10'b1001000100, 12'h240, 5'd3, 5'd2};
    localparam logic [31:0] BCOND       = {8'b01010100, 19'd4, 5'd1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a falling edge, then settle to the rising edge to sample.
    task automatic apply(input logic [31:0] ic, input logic mr, input logic rw,
                         input logic [4:0] rd, input logic bt);
        IC_in        = ic;
        ex_mem_read  = mr;
        ex_reg_write = rw;
        ex_rd        = rd;
        branch_taken = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        adv();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
`ifdef HAZARD_FLAG_EN
        ex_set_flags = 1'b0;
`endif
        // Reset with hazard and branch inputs active: outputs must still be 0
        apply(ADD_2_1_3, 1'b1, 1'b1, 5'd1, 1'b1);
        check("rst_hazard", 32'(Hazard_out), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        adv();
        check("rst_count", stall_count, 32'd0);
        reset = 1'b0;

        // LDUR X1 in EX, ADD X2,X1,X3 in ID
        apply(ADD_2_1_3, 1'b1, 1'b1, 5'd1, 1'b0);
        check("ldu_hazard", 32'(Hazard_out), 32'd1);
        check("ldu_bubble", 32'(bubble), 32'd1);
        check("ldu_flush", 32'(flush), 32'd0);
        adv();
        check("ldu_count", stall_count, 32'd1);
        apply(ADD_2_1_3, 1'b0, 1'b0, 5'd0, 1'b0);
        check("ldu_release", 32'(Hazard_out), 32'd0);
        adv();
        check("ldu_count2", stall_count, 32'd1);

        // LDUR X4 in EX, CBZ X4 in ID: two-cycle stall, branch ignored in second
        do_reset();
        apply(CBZ_4, 1'b1, 1'b1, 5'd4, 1'b0);
        check("cbz_ld_c1", 32'(Hazard_out), 32'd1);
        adv();
        check("cbz_ld_cnt1", stall_count, 32'd1);
        apply(CBZ_4, 1'b0, 1'b0, 5'd0, 1'b1);
        check("cbz_ld_c2", 32'(Hazard_out), 32'd1);
        check("cbz_ld_c2_bubble", 32'(bubble), 32'd1);
        check("cbz_ld_c2_flush", 32'(flush), 32'd0);
        adv();
        check("cbz_ld_cnt2", stall_count, 32'd2);
        apply(CBZ_4, 1'b0, 1'b0, 5'd0, 1'b0);
        check("cbz_ld_c3", 32'(Hazard_out), 32'd0);
        adv();
        check("cbz_ld_cnt3", stall_count, 32'd2);

        // XZR never hazards
        apply(ADD_2_31_3, 1'b1, 1'b1, 5'd31, 1'b0);
        check("xzr_hazard", 32'(Hazard_out), 32'd0);
        adv();

        // SUB X5 in EX, CBZ X5 in ID: single-cycle stall
        apply(CBZ_5, 1'b0, 1'b1, 5'd5, 1'b0);
        check("cbz_alu_c1", 32'(Hazard_out), 32'd1);
        adv();
        check("cbz_alu_cnt", stall_count, 32'd3);
        apply(CBZ_5, 1'b0, 1'b0, 5'd0, 1'b0);
        check("cbz_alu_c2", 32'(Hazard_out), 32'd0);
        adv();

        // Branch flush without and with a load-use stall
        apply(ADD_2_1_3, 1'b0, 1'b0, 5'd0, 1'b1);
        check("br_flush", 32'(flush), 32'd1);
        check("br_hazard", 32'(Hazard_out), 32'd0);
        adv();
        apply(ADD_2_1_3, 1'b1, 1'b1, 5'd1, 1'b1);
        check("br_stall_flush", 32'(flush), 32'd0);
        check("br_stall_hazard", 32'(Hazard_out), 32'd1);
        adv();
        check("br_stall_cnt", stall_count, 32'd4);

        // STUR reads Rt; B reads nothing
        apply(STUR_7_6, 1'b1, 1'b1, 5'd7, 1'b0);
        check("stur_rt", 32'(Hazard_out), 32'd1);
        adv();
        check("stur_cnt", stall_count, 32'd5);
        apply(B_IMM21, 1'b1, 1'b1, 5'd1, 1'b0);
        check("b_none", 32'(Hazard_out), 32'd0);
        adv();

        // ALU producer feeding a non-CBZ consumer is forwarded, not stalled
        apply(ADD_2_1_3, 1'b0, 1'b1, 5'd1, 1'b0);
        check("alu_fwd", 32'(Hazard_out), 32'd0);
        adv();
        apply(ADDI_2_3, 1'b1, 1'b1, 5'd3, 1'b0);
        check("addi_rn", 32'(Hazard_out), 32'd1);
        adv();
        check("addi_cnt", stall_count, 32'd6);
        apply(ADDI_IMM9, 1'b1, 1'b1, 5'd9, 1'b0);
        check("addi_no_rm", 32'(Hazard_out), 32'd0);
        adv();

        // Reset in the first STALL cycle aborts the stall
        apply(CBZ_4, 1'b1, 1'b1, 5'd4, 1'b0);
        check("abort_c1", 32'(Hazard_out), 32'd1);
        adv();
        check("abort_cnt1", stall_count, 32'd7);
        reset = 1'b1;
        apply(CBZ_4, 1'b0, 1'b0, 5'd0, 1'b0);
        check("abort_in_rst", 32'(Hazard_out), 32'd0);
        adv();
        reset = 1'b0;
        apply(CBZ_4, 1'b0, 1'b0, 5'd0, 1'b0);
        check("abort_after", 32'(Hazard_out), 32'd0);
        check("abort_cnt", stall_count, 32'd0);
        adv();

        // SUBS in EX, B.cond in ID
`ifdef HAZARD_FLAG_EN
        ex_set_flags = 1'b1;
`endif
        apply(BCOND, 1'b0, 1'b1, 5'd9, 1'b0);
        check("bcond_hazard", 32'(Hazard_out), 32'(FLAG_EXP));
        adv();
        check("bcond_cnt", stall_count, 32'(FLAG_EXP));
`ifdef HAZARD_FLAG_EN
        ex_set_flags = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
